// File: rtl/sram_controller.sv
// Two-port round-robin arbiter and registered strobe sequencer for the async SRAM macro.
// All SRAM-facing strobes, the address and the data-bus enable come from flops. Each is
// loaded from the next state, so the pins follow the FSM with no combinational path
// from the request inputs.
module sram_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WRITE_PULSE = 2,
  parameter int READ_WAIT   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_chip_enable,
  output logic                  sram_write_enable,
  output logic                  sram_output_enable
);

  // state      | meaning
  // IDLE       | arbitrate and capture a request
  // WR_SETUP   | address and data settle, write_enable still high
  // WR_PULSE   | write_enable low for WRITE_PULSE cycles
  // WR_HOLD    | write_enable released, data still driven
  // RD_ACCESS  | output_enable low for READ_WAIT cycles, sample on last edge
  // DONE       | bus turnaround and completion pulse, no accept
  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, DONE} state_t;

  localparam logic [7:0] WP_LOAD = 8'(WRITE_PULSE - 1);
  localparam logic [7:0] RW_LOAD = 8'(READ_WAIT - 1);

  state_t                  state, next_state;
  logic [7:0]              count;
  logic                    grant_port;
  logic                    last_grant;
  logic                    pick;
  logic                    data_drive;
  logic [DATA_WIDTH-1:0]   wdata_q;

  assign sram_data = data_drive ? wdata_q : 'z;

  // Arbitration and next-state selection.
  always_comb begin
    next_state = state;
    pick       = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the port that was not granted last wins.
          pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          next_state = (pick ? req1_write : req0_write) ? WR_SETUP : RD_ACCESS;
        end
      end
      WR_SETUP:  next_state = WR_PULSE;
      WR_PULSE:  if (count == 8'd0) next_state = WR_HOLD;
      WR_HOLD:   next_state = DONE;
      RD_ACCESS: if (count == 8'd0) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State, counter, captured request and registered SRAM pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      count              <= 8'd0;
      grant_port         <= 1'b0;
      last_grant         <= 1'b1;
      data_drive         <= 1'b0;
      wdata_q            <= '0;
      sram_address       <= '0;
      sram_chip_enable   <= 1'b1;
      sram_write_enable  <= 1'b1;
      sram_output_enable <= 1'b1;
      req0_done          <= 1'b0;
      req1_done          <= 1'b0;
      req0_rdata         <= '0;
      req1_rdata         <= '0;
    end else begin
      state <= next_state;

      if (state == IDLE && next_state == RD_ACCESS)
        count <= RW_LOAD;
      else if (state == WR_SETUP)
        count <= WP_LOAD;
      else if ((state == WR_PULSE || state == RD_ACCESS) && count != 8'd0)
        count <= count - 8'd1;

      if (state == IDLE && next_state != IDLE) begin
        grant_port   <= pick;
        last_grant   <= pick;
        sram_address <= pick ? req1_address : req0_address;
        wdata_q      <= pick ? req1_wdata   : req0_wdata;
      end

      sram_chip_enable   <= (next_state == IDLE || next_state == DONE);
      sram_write_enable  <= (next_state != WR_PULSE);
      sram_output_enable <= (next_state != RD_ACCESS);
      data_drive         <= (next_state == WR_SETUP || next_state == WR_PULSE ||
                             next_state == WR_HOLD);

      req0_done <= (next_state == DONE) && !grant_port;
      req1_done <= (next_state == DONE) &&  grant_port;

      if (state == RD_ACCESS && count == 8'd0) begin
        if (grant_port) req1_rdata <= sram_data;
        else            req0_rdata <= sram_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a default-parameter instance (a) and a WRITE_PULSE=1,
// READ_WAIT=3 instance (b), each wired to a simple behavioural async SRAM.
module tb_sram_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  int errors = 0;
  int checks = 0;

  logic        a_v0, a_w0, a_v1, a_w1, a_d0, a_d1;
  logic [7:0]  a_ad0, a_ad1, a_addr;
  logic [15:0] a_wd0, a_wd1, a_rd0, a_rd1;
  logic        a_ce, a_we, a_oe;
  wire  [15:0] a_bus;

  logic        b_v0, b_w0, b_v1, b_w1, b_d0, b_d1;
  logic [7:0]  b_ad0, b_ad1, b_addr;
  logic [15:0] b_wd0, b_wd1, b_rd0, b_rd1;
  logic        b_ce, b_we, b_oe;
  wire  [15:0] b_bus;

  sram_controller u_a (
    .clock(clock), .reset(reset),
    .req0_valid(a_v0), .req0_write(a_w0), .req0_address(a_ad0), .req0_wdata(a_wd0),
    .req0_done(a_d0), .req0_rdata(a_rd0),
    .req1_valid(a_v1), .req1_write(a_w1), .req1_address(a_ad1), .req1_wdata(a_wd1),
    .req1_done(a_d1), .req1_rdata(a_rd1),
    .sram_address(a_addr), .sram_data(a_bus), .sram_chip_enable(a_ce),
    .sram_write_enable(a_we), .sram_output_enable(a_oe));

  sram_controller #(.WRITE_PULSE(1), .READ_WAIT(3)) u_b (
    .clock(clock), .reset(reset),
    .req0_valid(b_v0), .req0_write(b_w0), .req0_address(b_ad0), .req0_wdata(b_wd0),
    .req0_done(b_d0), .req0_rdata(b_rd0),
    .req1_valid(b_v1), .req1_write(b_w1), .req1_address(b_ad1), .req1_wdata(b_wd1),
    .req1_done(b_d1), .req1_rdata(b_rd1),
    .sram_address(b_addr), .sram_data(b_bus), .sram_chip_enable(b_ce),
    .sram_write_enable(b_we), .sram_output_enable(b_oe));

  // Behavioural SRAMs: drive the bus while selected with output_enable low.
  logic [15:0] a_mem [256];
  logic [15:0] b_mem [256];
  assign a_bus = (!a_ce && !a_oe) ? a_mem[a_addr] : 'z;
  assign b_bus = (!b_ce && !b_oe) ? b_mem[b_addr] : 'z;
  always @(posedge clock) if (!a_ce && !a_we) a_mem[a_addr] <= a_bus;
  always @(posedge clock) if (!b_ce && !b_we) b_mem[b_addr] <= b_bus;

  // Bus-safety monitor on instance a.
  logic mon_en = 1'b0;
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (!a_oe && u_a.data_drive) begin
        errors++;
        $display("FAIL bus_overlap: oe=%0b drive=%0b, required not both active", a_oe, u_a.data_drive);
      end else if ((!a_oe || !a_we) && a_ce) begin
        errors++;
        $display("FAIL ce_active: ce=%0b with we=%0b oe=%0b, required ce=0", a_ce, a_we, a_oe);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input int port, input logic v, input logic w,
                         input logic [7:0] ad, input logic [15:0] wd);
    if (sel == 0 && port == 0)      begin a_v0 = v; a_w0 = w; a_ad0 = ad; a_wd0 = wd; end
    else if (sel == 0)              begin a_v1 = v; a_w1 = w; a_ad1 = ad; a_wd1 = wd; end
    else                            begin b_v0 = v; b_w0 = w; b_ad0 = ad; b_wd0 = wd; end
  endtask

  function automatic logic [2:0] ctl(input int sel);
    return (sel == 0) ? {a_ce, a_we, a_oe} : {b_ce, b_we, b_oe};
  endfunction

  function automatic logic get_done(input int sel, input int port);
    if (sel == 0) return (port == 0) ? a_d0 : a_d1;
    return b_d0;
  endfunction

  function automatic logic [15:0] get_rdata(input int sel, input int port);
    if (sel == 0) return (port == 0) ? a_rd0 : a_rd1;
    return b_rd0;
  endfunction

  // Issues one request starting in an IDLE cycle and returns what was observed.
  task automatic run_op(input int sel, input int port, input logic wr, input logic [7:0] ad,
                        input logic [15:0] wd, output int lat, output int we_lo,
                        output int oe_lo, output logic [15:0] rd, output int bus_bad,
                        output int other_done);
    logic [2:0] c;
    bit fin;
    lat = 0; we_lo = 0; oe_lo = 0; bus_bad = 0; other_done = 0; rd = '0; fin = 0;
    set_req(sel, port, 1'b1, wr, ad, wd);
    while (!fin && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      c = ctl(sel);
      if (!c[1]) begin
        we_lo++;
        if (((sel == 0) ? a_bus : b_bus) !== wd) bus_bad++;
      end
      if (!c[0]) oe_lo++;
      if (sel == 0 && get_done(0, 1 - port)) other_done++;
      if (get_done(sel, port)) begin
        fin = 1;
        rd  = get_rdata(sel, port);
        set_req(sel, port, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end
    if (!fin) set_req(sel, port, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(posedge clock); #1;
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [7:0]  ad;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  logic [15:0] sb [256];
  int          lat, we_lo, oe_lo, bus_bad, other_done;
  logic [15:0] rd;

  initial begin
    for (int i = 0; i < 256; i++) begin a_mem[i] = '0; b_mem[i] = '0; sb[i] = '0; end
    set_req(0, 0, 0, 0, 8'h00, 16'h0000);
    set_req(0, 1, 0, 0, 8'h00, 16'h0000);
    set_req(1, 0, 0, 0, 8'h00, 16'h0000);
    b_v1 = 0; b_w1 = 0; b_ad1 = '0; b_wd1 = '0;

    vecs[0] = '{0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 5};
    vecs[1] = '{0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 3};
    vecs[2] = '{1, 1'b1, 8'h01, 16'h1111, 16'h0000, 5};
    vecs[3] = '{0, 1'b1, 8'h02, 16'h2222, 16'h0000, 5};
    vecs[4] = '{1, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 3};
    vecs[5] = '{0, 1'b0, 8'h01, 16'h0000, 16'h1111, 3};
    vecs[6] = '{1, 1'b1, 8'h00, 16'hFFFF, 16'h0000, 5};
    vecs[7] = '{0, 1'b0, 8'h00, 16'h0000, 16'hFFFF, 3};
    vecs[8] = '{1, 1'b0, 8'h02, 16'h0000, 16'h2222, 3};
    vecs[9] = '{0, 1'b1, 8'hFF, 16'h0000, 16'h0000, 5};

    // Reset held 3 cycles with both ports requesting.
    reset = 1;
    a_v0 = 1; a_v1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("reset_ctl", {29'd0, a_ce, a_we, a_oe}, 32'h7);
      check("reset_done_drive", {29'd0, a_d0, a_d1, u_a.data_drive}, 32'h0);
      check("reset_rdata_addr", {a_rd0 | a_rd1, 8'h00, a_addr}, 32'h0);
    end
    reset = 0;
    begin
      int n = 0;
      while (!a_d0 && !a_d1 && n < 20) begin @(posedge clock); #1; n++; end
      check("first_grant_port0", {30'd0, a_d0, a_d1}, 32'h2);
      check("first_grant_lat", n, 3);
    end
    a_v0 = 0; a_v1 = 0;
    @(posedge clock); #1;

    // Directed vectors on the default instance.
    for (int i = 0; i < 10; i++) begin
      run_op(0, vecs[i].port, vecs[i].wr, vecs[i].ad, vecs[i].wd,
             lat, we_lo, oe_lo, rd, bus_bad, other_done);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_other_done", i), other_done, 0);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_we_low", i), we_lo, 2);
        check($sformatf("vec%0d_bus", i), bus_bad, 0);
        check($sformatf("vec%0d_oe_low", i), oe_lo, 0);
      end else begin
        check($sformatf("vec%0d_oe_low", i), oe_lo, 2);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d_we_low", i), we_lo, 0);
      end
    end

    // Contention after a reset pulse: port 0 first, then strict alternation.
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    set_req(0, 0, 1, 0, 8'h01, 16'h0000);
    set_req(0, 1, 1, 0, 8'h02, 16'h0000);
    begin
      int order [4];
      int when [4];
      int got = 0;
      int n = 0;
      while (got < 4 && n < 60) begin
        @(posedge clock); #1; n++;
        if (a_d0 || a_d1) begin
          order[got] = a_d1 ? 1 : 0;
          when[got]  = n;
          if (a_d0) check("cont_rdata0", a_rd0, 16'h1111);
          else      check("cont_rdata1", a_rd1, 16'h2222);
          got++;
        end
      end
      a_v0 = 0; a_v1 = 0;
      check("cont_count", got, 4);
      if (got == 4) begin
        for (int k = 0; k < 4; k++) check($sformatf("cont_order%0d", k), order[k], k % 2);
        check("cont_first_lat", when[0], 3);
        for (int k = 1; k < 4; k++) check($sformatf("cont_gap%0d", k), when[k] - when[k-1], 4);
      end
    end
    @(posedge clock); #1;

    // Reset during the first write pulse cycle.
    set_req(0, 0, 1, 1, 8'h30, 16'hAAAA);
    @(posedge clock); #1;
    check("mwr_setup_ctl", {29'd0, ctl(0)}, 32'h3);
    @(posedge clock); #1;
    check("mwr_pulse_ctl", {29'd0, ctl(0)}, 32'h1);
    reset = 1;
    set_req(0, 0, 0, 0, 8'h00, 16'h0000);
    @(posedge clock); #1;
    reset = 0;
    check("mwr_abort_ctl", {29'd0, ctl(0)}, 32'h7);
    check("mwr_abort_drive_done", {29'd0, u_a.data_drive, a_d0, a_d1}, 32'h0);
    begin
      int seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clock); #1;
        if (a_d0 || a_d1) seen++;
      end
      check("mwr_no_done", seen, 0);
    end
    run_op(0, 1, 1'b0, 8'h10, 16'h0000, lat, we_lo, oe_lo, rd, bus_bad, other_done);
    check("mwr_after_lat", lat, 3);
    check("mwr_after_rdata", rd, 16'hBEEF);

    // Overridden-parameter instance.
    run_op(1, 0, 1'b1, 8'hFF, 16'h1234, lat, we_lo, oe_lo, rd, bus_bad, other_done);
    check("p_write_lat", lat, 4);
    check("p_write_we_low", we_lo, 1);
    check("p_write_bus", bus_bad, 0);
    run_op(1, 0, 1'b0, 8'hFF, 16'h0000, lat, we_lo, oe_lo, rd, bus_bad, other_done);
    check("p_read_lat", lat, 4);
    check("p_read_oe_low", oe_lo, 3);
    check("p_read_rdata", rd, 16'h1234);

    // Random mixed traffic on both ports with a scoreboard.
    mon_en = 1;
    for (int i = 0; i < 8; i++) begin
      run_op(0, 0, 1'b1, 8'(8'h40 + i), 16'(16'h0111 * (i + 1)), lat, we_lo, oe_lo, rd,
             bus_bad, other_done);
      sb[8'h40 + i] = 16'(16'h0111 * (i + 1));
    end
    begin
      bit          pend [2];
      bit          pw   [2];
      logic [7:0]  pa   [2];
      logic [15:0] pd   [2];
      int          age  [2];
      bit          stop = 0;
      for (int p = 0; p < 2; p++) begin pend[p] = 0; age[p] = 0; end
      for (int cyc = 0; cyc < 10200; cyc++) begin
        @(posedge clock); #1;
        if (cyc >= 10000) stop = 1;
        for (int p = 0; p < 2; p++) begin
          if (pend[p]) begin
            age[p]++;
            if (get_done(0, p)) begin
              pend[p] = 0;
              set_req(0, p, 0, 0, 8'h00, 16'h0000);
              if (pw[p]) sb[pa[p]] = pd[p];
              else check($sformatf("rand_read_p%0d_a%0h", p, pa[p]), get_rdata(0, p), sb[pa[p]]);
            end else if (age[p] > 60) begin
              check($sformatf("rand_timeout_p%0d", p), age[p], 0);
              pend[p] = 0;
              set_req(0, p, 0, 0, 8'h00, 16'h0000);
            end
          end else begin
            if (get_done(0, p)) check($sformatf("rand_spurious_done_p%0d", p), 1, 0);
            if (!stop && $urandom_range(0, 2) == 0) begin
              pend[p] = 1;
              age[p]  = 0;
              pw[p]   = 1'($urandom_range(0, 1));
              pa[p]   = 8'(8'h40 + $urandom_range(0, 7));
              pd[p]   = 16'($urandom);
              set_req(0, p, 1, pw[p], pa[p], pd[p]);
            end
          end
        end
      end
      check("rand_drained", {30'd0, pend[0], pend[1]}, 32'h0);
    end
    mon_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
